// File: rtl/move_scheduler_if.sv
// rtl/move_scheduler_if.sv - candidate/checker handshake between move_scheduler and the collision checker
//
// Signals:
//   cand_valid  scheduler -> checker  candidate presented, held until chk_done
//   cand_x      scheduler -> checker  candidate x
//   cand_y      scheduler -> checker  candidate y
//   cand_rot    scheduler -> checker  candidate rotation 0..3
//   chk_done    checker -> scheduler  result valid (only while cand_valid=1)
//   chk_ok      checker -> scheduler  1 = candidate collision-free
interface move_scheduler_if;
  logic       cand_valid;
  logic [9:0] cand_x;
  logic [9:0] cand_y;
  logic [9:0] cand_rot;
  logic       chk_done;
  logic       chk_ok;

  modport master (
    output cand_valid, cand_x, cand_y, cand_rot,
    input  chk_done, chk_ok
  );

  modport slave (
    input  cand_valid, cand_x, cand_y, cand_rot,
    output chk_done, chk_ok
  );
endinterface

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - arbitrates button/gravity moves of the falling piece through the collision checker
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   btn_left/right/down/rot         raw asynchronous button levels
//   spawn                           1-cycle pulse: load spawn position, clear pending, unlock
//   chk (move_scheduler_if.master)  candidate out, checker verdict in
//   pos_x, pos_y, rot               committed piece state
//   locked                          piece has landed, no moves issued
//   lock_pulse                      1-cycle pulse on the edge entering LOCKED
module move_scheduler #(
  parameter int GRAV_DIV = 50_000_000,
  parameter int FIELD_W  = 10,
  parameter int SPAWN_X  = 4,
  parameter int SPAWN_Y  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_down,
  input  logic             btn_rot,
  input  logic             spawn,
  move_scheduler_if.master chk,
  output logic [9:0]       pos_x,
  output logic [9:0]       pos_y,
  output logic [9:0]       rot,
  output logic             locked,
  output logic             lock_pulse
);

  localparam int CW = $clog2(GRAV_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(GRAV_DIV - 1);
  localparam logic [9:0] X_MAX = 10'(FIELD_W - 1);

  // Source bit positions; the priority order is grav > rot > left > right > down.
  localparam int SRC_DOWN  = 0;
  localparam int SRC_RIGHT = 1;
  localparam int SRC_LEFT  = 2;
  localparam int SRC_ROT   = 3;
  localparam int SRC_GRAV  = 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [3:0]      btn_raw, btn_rise;
  logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [4:0]      pend_q, pend_d, sel;
  logic [CW-1:0]   grav_cnt_q, grav_cnt_d;
  logic            grav_tick;
  logic [9:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d, rot_q, rot_d;
  logic [9:0]      cand_x_q, cand_x_d, cand_y_q, cand_y_d, cand_rot_q, cand_rot_d;
  logic [9:0]      nx, ny, nr;
  logic            cand_valid_q, cand_valid_d;
  logic            fall_q, fall_d;
  logic            lock_pulse_q, lock_pulse_d;
  logic            sel_fall, blocked, issue;

  // Bit order matches the SRC_* positions of the button sources.
  assign btn_raw  = {btn_rot, btn_left, btn_right, btn_down};
  assign btn_rise = sync2_q & ~prev_q;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Highest-priority pending source and the candidate it would produce.
  always_comb begin
    sel = '0;
    if (pend_q[SRC_GRAV])       sel[SRC_GRAV]  = 1'b1;
    else if (pend_q[SRC_ROT])   sel[SRC_ROT]   = 1'b1;
    else if (pend_q[SRC_LEFT])  sel[SRC_LEFT]  = 1'b1;
    else if (pend_q[SRC_RIGHT]) sel[SRC_RIGHT] = 1'b1;
    else if (pend_q[SRC_DOWN])  sel[SRC_DOWN]  = 1'b1;

    nx = pos_x_q;
    ny = pos_y_q;
    nr = rot_q;
    if (sel[SRC_GRAV] || sel[SRC_DOWN]) ny = pos_y_q + 10'd1;
    if (sel[SRC_ROT])                   nr = {8'd0, rot_q[1:0] + 2'd1};
    if (sel[SRC_LEFT])                  nx = pos_x_q - 10'd1;
    if (sel[SRC_RIGHT])                 nx = pos_x_q + 10'd1;
  end

  assign sel_fall = sel[SRC_GRAV] | sel[SRC_DOWN];
  // A sideways move off the field edge is dropped instead of wrapping.
  assign blocked  = (sel[SRC_LEFT] && pos_x_q == 10'd0) || (sel[SRC_RIGHT] && pos_x_q == X_MAX);
  assign issue    = (state_q == S_IDLE) && !spawn && (|pend_q) && !blocked;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (spawn) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (issue) state_d = S_REQ;
        S_REQ:    if (chk.chk_done) state_d = (!chk.chk_ok && fall_q) ? S_LOCKED : S_IDLE;
        S_LOCKED: state_d = S_LOCKED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs and datapath
  always_comb begin
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    rot_d        = rot_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    cand_rot_d   = cand_rot_q;
    cand_valid_d = cand_valid_q;
    fall_d       = fall_q;
    lock_pulse_d = 1'b0;
    pend_d       = pend_q;

    if (spawn || state_q == S_LOCKED) grav_cnt_d = '0;
    else if (grav_cnt_q == CNT_MAX)   grav_cnt_d = '0;
    else                              grav_cnt_d = grav_cnt_q + CW'(1);
    grav_tick = !spawn && (state_q != S_LOCKED) && (grav_cnt_d == CNT_MAX);

    if (spawn) begin
      pos_x_d      = 10'(SPAWN_X);
      pos_y_d      = 10'(SPAWN_Y);
      rot_d        = 10'd0;
      pend_d       = '0;
      cand_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The selected flag clears whether the move is issued or dropped at the edge.
          pend_d = pend_q & ~sel;
          if (issue) begin
            cand_x_d     = nx;
            cand_y_d     = ny;
            cand_rot_d   = nr;
            cand_valid_d = 1'b1;
            fall_d       = sel_fall;
          end
        end
        S_REQ: begin
          if (chk.chk_done) begin
            cand_valid_d = 1'b0;
            if (chk.chk_ok) begin
              pos_x_d = cand_x_q;
              pos_y_d = cand_y_q;
              rot_d   = cand_rot_q;
            end else if (fall_q) begin
              lock_pulse_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
      // New edges merge into pending flags; a landed piece ignores them.
      if (state_q != S_LOCKED) pend_d = pend_d | {grav_tick, btn_rise};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      pend_q       <= '0;
      grav_cnt_q   <= '0;
      pos_x_q      <= 10'(SPAWN_X);
      pos_y_q      <= 10'(SPAWN_Y);
      rot_q        <= 10'd0;
      cand_x_q     <= 10'd0;
      cand_y_q     <= 10'd0;
      cand_rot_q   <= 10'd0;
      cand_valid_q <= 1'b0;
      fall_q       <= 1'b0;
      lock_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      pend_q       <= pend_d;
      grav_cnt_q   <= grav_cnt_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      rot_q        <= rot_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      cand_rot_q   <= cand_rot_d;
      cand_valid_q <= cand_valid_d;
      fall_q       <= fall_d;
      lock_pulse_q <= lock_pulse_d;
    end
  end

  assign chk.cand_valid = cand_valid_q;
  assign chk.cand_x     = cand_x_q;
  assign chk.cand_y     = cand_y_q;
  assign chk.cand_rot   = cand_rot_q;
  assign pos_x          = pos_x_q;
  assign pos_y          = pos_y_q;
  assign rot            = rot_q;
  assign locked         = (state_q == S_LOCKED);
  assign lock_pulse     = lock_pulse_q;

endmodule
